// File: rtl/nim_trig_sched.sv
// nim_trig_sched: NIM trigger scheduler.
//
// Conditions N_CH channel triggers into rising edges, combines the masked edges
// either as an OR or as a coincidence (AND) inside a programmable window, then
// issues one registered output pulse followed by an optional dead time.
//
// Ports:
//   clk          single clock for all logic
//   reset        asynchronous, active-low reset
//   enable       global arm; 0 blocks new triggers and aborts an open window
//   ch_mask      channel participates when its bit is 1
//   mode         0 = OR of masked channels, 1 = coincidence of masked channels
//   window       coincidence window in clk cycles after the first edge
//   width        output pulse width in clk cycles (0 behaves as 1)
//   deadtime     hold-off cycles after the pulse
//   veto         synchronous veto; blocks new triggers and aborts an open window
//   count_clr    synchronous clear of trig_count
//   trig_in      conditioned channel triggers
//   trig_out     scheduled trigger pulse (registered)
//   busy         high whenever the scheduler is not idle
//   trig_pattern masked channel pattern of the last accepted trigger
//   trig_count   number of accepted triggers, wraps modulo 2^CNT_W
module nim_trig_sched #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             mode,
    input  logic [7:0]       window,
    input  logic [7:0]       width,
    input  logic [15:0]      deadtime,
    input  logic             veto,
    input  logic             count_clr,
    input  logic [N_CH-1:0]  trig_in,
    output logic             trig_out,
    output logic             busy,
    output logic [N_CH-1:0]  trig_pattern,
    output logic [CNT_W-1:0] trig_count
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWindow = 2'd1;
    localparam logic [1:0] StFire   = 2'd2;
    localparam logic [1:0] StDead   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [N_CH-1:0] s_q, s_dly_q;
    logic [N_CH-1:0] seen_low_q;
    logic [N_CH-1:0] pat_q, pat_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic [15:0]     dcnt_q, dcnt_d;
    logic [7:0]      width_q, width_d;
    logic [15:0]     dead_q, dead_d;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] new_pat;
    logic            fire_entry;

    // A channel only counts as rising once it has been seen low since reset, so
    // an input held high through reset release cannot fake an edge.
    assign rise    = s_q & ~s_dly_q & ch_mask & seen_low_q;
    assign new_pat = pat_q | rise;
    assign busy    = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        wcnt_d     = wcnt_q;
        fcnt_d     = fcnt_q;
        dcnt_d     = dcnt_q;
        width_d    = width_q;
        dead_d     = dead_q;
        fire_entry = 1'b0;
        case (state_q)
            StIdle: begin
                pat_d = '0;
                if (enable && !veto && (|rise)) begin
                    width_d = width;
                    dead_d  = deadtime;
                    if (!mode || (rise == ch_mask)) begin
                        state_d    = StFire;
                        fire_entry = 1'b1;
                        fcnt_d     = (width == 8'd0) ? 8'd0 : width - 8'd1;
                        pat_d      = rise;
                    end else if (window != 8'd0) begin
                        state_d = StWindow;
                        wcnt_d  = window;
                        pat_d   = rise;
                    end
                end
            end
            StWindow: begin
                if (veto || !enable) begin
                    state_d = StIdle;
                    pat_d   = '0;
                end else if (new_pat == ch_mask) begin
                    state_d    = StFire;
                    fire_entry = 1'b1;
                    fcnt_d     = (width_q == 8'd0) ? 8'd0 : width_q - 8'd1;
                    pat_d      = new_pat;
                end else begin
                    pat_d  = new_pat;
                    wcnt_d = wcnt_q - 8'd1;
                    if (wcnt_q == 8'd1) begin
                        state_d = StIdle;
                        pat_d   = '0;
                    end
                end
            end
            StFire: begin
                if (fcnt_q == 8'd0) begin
                    pat_d = '0;
                    if (dead_q == 16'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDead;
                        dcnt_d  = dead_q - 16'd1;
                    end
                end else begin
                    fcnt_d = fcnt_q - 8'd1;
                end
            end
            StDead: begin
                if (dcnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    dcnt_d = dcnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                pat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            s_q          <= '0;
            s_dly_q      <= '0;
            seen_low_q   <= '0;
            pat_q        <= '0;
            wcnt_q       <= '0;
            fcnt_q       <= '0;
            dcnt_q       <= '0;
            width_q      <= '0;
            dead_q       <= '0;
            trig_out     <= 1'b0;
            trig_pattern <= '0;
            trig_count   <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= trig_in;
            s_dly_q    <= s_q;
            seen_low_q <= seen_low_q | ~trig_in;
            pat_q      <= pat_d;
            wcnt_q     <= wcnt_d;
            fcnt_q     <= fcnt_d;
            dcnt_q     <= dcnt_d;
            width_q    <= width_d;
            dead_q     <= dead_d;
            // Pulse follows the FIRE state one cycle later, so its length equals
            // the number of cycles spent in FIRE.
            trig_out   <= (state_q == StFire);
            if (fire_entry) begin
                trig_pattern <= new_pat;
                // A clear coinciding with an accepted trigger still counts it.
                trig_count   <= count_clr ? CNT_W'(1) : trig_count + CNT_W'(1);
            end else if (count_clr) begin
                trig_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nim_trig_sched.sv
// Directed testbench for nim_trig_sched (N_CH = 4, CNT_W = 4 so the counter
// wrap is reachable in a short run).
module tb_nim_trig_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] ch_mask;
    logic       mode;
    logic [7:0] window;
    logic [7:0] width;
    logic [15:0] deadtime;
    logic       veto;
    logic       count_clr;
    logic [3:0] trig_in;
    logic       trig_out;
    logic       busy;
    logic [3:0] trig_pattern;
    logic [3:0] trig_count;

    int checks   = 0;
    int failures = 0;

    nim_trig_sched #(
        .N_CH (4),
        .CNT_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .mode        (mode),
        .window      (window),
        .width       (width),
        .deadtime    (deadtime),
        .veto        (veto),
        .count_clr   (count_clr),
        .trig_in     (trig_in),
        .trig_out    (trig_out),
        .busy        (busy),
        .trig_pattern(trig_pattern),
        .trig_count  (trig_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic m, input logic [3:0] mk, input logic [7:0] win,
                       input logic [7:0] wid, input logic [15:0] dt);
        mode     = m;
        ch_mask  = mk;
        window   = win;
        width    = wid;
        deadtime = dt;
        tick;
    endtask

    // Runs n edges; at edge k the DUT samples trig_in = (k==ka ? a) | (k==kb ? b),
    // veto = (k==kv), count_clr = (k==kc). Reports the first edge index after
    // which trig_out was high, and how many edges left trig_out / busy high.
    task automatic run_sched(input logic [3:0] a, input int ka, input logic [3:0] b,
                             input int kb, input int kv, input int kc, input int n,
                             output int first_out, output int n_out, output int n_busy);
        first_out = 0;
        n_out     = 0;
        n_busy    = 0;
        for (int k = 1; k <= n; k++) begin
            trig_in   = ((k == ka) ? a : 4'b0000) | ((k == kb) ? b : 4'b0000);
            veto      = (k == kv);
            count_clr = (k == kc);
            tick;
            if (trig_out === 1'b1) begin
                n_out++;
                if (first_out == 0) first_out = k;
            end
            if (busy === 1'b1) n_busy++;
        end
        trig_in   = 4'b0000;
        veto      = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (trig_out !== 1'b0) begin
            failures++; $display("FAIL reset_trig_out got=%b exp=0", trig_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (trig_pattern !== 4'b0000) begin
            failures++; $display("FAIL reset_pattern got=%b exp=0000", trig_pattern);
        end
        checks++;
        if (trig_count !== 4'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", trig_count);
        end
    endtask

    task automatic test_or_mode;
        int f, no, nb;
        cfg(1'b0, 4'b0011, 8'd0, 8'd4, 16'd10);
        run_sched(4'b0010, 1, 4'b0000, 0, 0, 0, 20, f, no, nb);
        checks++;
        if (f != 3) begin failures++; $display("FAIL or_latency got=%0d exp=3", f); end
        checks++;
        if (no != 4) begin failures++; $display("FAIL or_width got=%0d exp=4", no); end
        checks++;
        if (nb != 14) begin failures++; $display("FAIL or_busy got=%0d exp=14", nb); end
        checks++;
        if (trig_pattern !== 4'b0010) begin
            failures++; $display("FAIL or_pattern got=%b exp=0010", trig_pattern);
        end
        checks++;
        if (trig_count !== 4'd1) begin
            failures++; $display("FAIL or_count got=%0d exp=1", trig_count);
        end
    endtask

    task automatic test_and_mode;
        int f, no, nb;
        cfg(1'b1, 4'b0101, 8'd5, 8'd2, 16'd0);
        run_sched(4'b0001, 1, 4'b0100, 4, 0, 0, 12, f, no, nb);
        checks++;
        if (f != 6 || no != 2) begin
            failures++; $display("FAIL and_hit_pulse got=%0d/%0d exp=6/2", f, no);
        end
        checks++;
        if (trig_pattern !== 4'b0101) begin
            failures++; $display("FAIL and_pattern got=%b exp=0101", trig_pattern);
        end
        checks++;
        if (trig_count !== 4'd2) begin
            failures++; $display("FAIL and_count got=%0d exp=2", trig_count);
        end
        run_sched(4'b0001, 1, 4'b0100, 8, 0, 0, 20, f, no, nb);
        checks++;
        if (no != 0) begin failures++; $display("FAIL and_miss_pulse got=%0d exp=0", no); end
        checks++;
        if (trig_count !== 4'd2) begin
            failures++; $display("FAIL and_miss_count got=%0d exp=2", trig_count);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL and_miss_idle got=%b exp=0", busy); end
    endtask

    task automatic test_veto;
        int f, no, nb;
        cfg(1'b1, 4'b0101, 8'd5, 8'd2, 16'd0);
        run_sched(4'b0001, 1, 4'b0000, 0, 3, 0, 12, f, no, nb);
        checks++;
        if (no != 0) begin failures++; $display("FAIL veto_window_pulse got=%0d exp=0", no); end
        checks++;
        if (nb != 1) begin failures++; $display("FAIL veto_window_busy got=%0d exp=1", nb); end
        checks++;
        if (trig_count !== 4'd2) begin
            failures++; $display("FAIL veto_window_count got=%0d exp=2", trig_count);
        end
        cfg(1'b0, 4'b0011, 8'd0, 8'd4, 16'd0);
        run_sched(4'b0001, 1, 4'b0000, 0, 3, 0, 10, f, no, nb);
        checks++;
        if (f != 3 || no != 4) begin
            failures++; $display("FAIL veto_fire_pulse got=%0d/%0d exp=3/4", f, no);
        end
        checks++;
        if (trig_count !== 4'd3 || trig_pattern !== 4'b0001) begin
            failures++;
            $display("FAIL veto_fire_result got=%0d/%b exp=3/0001", trig_count, trig_pattern);
        end
    endtask

    task automatic test_deadtime;
        int f, no, nb;
        cfg(1'b0, 4'b0001, 8'd0, 8'd4, 16'd10);
        run_sched(4'b0000, 0, 4'b0000, 0, 0, 1, 2, f, no, nb);
        checks++;
        if (trig_count !== 4'd0) begin
            failures++; $display("FAIL clr_alone got=%0d exp=0", trig_count);
        end
        // Second edge at k=8 lands in DEAD; the next call's k=1 is the first
        // cycle after DEAD ends.
        run_sched(4'b0001, 1, 4'b0001, 8, 0, 0, 15, f, no, nb);
        checks++;
        if (no != 4) begin failures++; $display("FAIL dead_first_pulse got=%0d exp=4", no); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL dead_still_busy got=%b exp=1", busy); end
        checks++;
        if (trig_count !== 4'd1) begin
            failures++; $display("FAIL dead_ignored_count got=%0d exp=1", trig_count);
        end
        run_sched(4'b0001, 1, 4'b0000, 0, 0, 0, 20, f, no, nb);
        checks++;
        if (f != 3 || no != 4) begin
            failures++; $display("FAIL dead_after_pulse got=%0d/%0d exp=3/4", f, no);
        end
        checks++;
        if (trig_count !== 4'd2) begin
            failures++; $display("FAIL dead_after_count got=%0d exp=2", trig_count);
        end
    endtask

    task automatic test_width_zero;
        int f, no, nb;
        cfg(1'b0, 4'b0001, 8'd0, 8'd0, 16'd0);
        run_sched(4'b0001, 1, 4'b0000, 0, 0, 2, 6, f, no, nb);
        checks++;
        if (f != 3 || no != 1) begin
            failures++; $display("FAIL w0_pulse got=%0d/%0d exp=3/1", f, no);
        end
        checks++;
        if (trig_count !== 4'd1) begin
            failures++; $display("FAIL w0_clr_fire_count got=%0d exp=1", trig_count);
        end
        run_sched(4'b0000, 0, 4'b0000, 0, 0, 1, 2, f, no, nb);
        checks++;
        if (trig_count !== 4'd0) begin
            failures++; $display("FAIL w0_clr_alone got=%0d exp=0", trig_count);
        end
    endtask

    task automatic test_wrap;
        int f, no, nb;
        for (int i = 0; i < 15; i++) begin
            run_sched(4'b0001, 1, 4'b0000, 0, 0, 0, 4, f, no, nb);
        end
        checks++;
        if (trig_count !== 4'd15) begin
            failures++; $display("FAIL wrap_preset got=%0d exp=15", trig_count);
        end
        run_sched(4'b0001, 1, 4'b0000, 0, 0, 0, 4, f, no, nb);
        checks++;
        if (trig_count !== 4'd0 || no != 1) begin
            failures++; $display("FAIL wrap_count got=%0d/%0d exp=0/1", trig_count, no);
        end
    endtask

    task automatic test_mask_zero;
        int f, no, nb;
        cfg(1'b0, 4'b0000, 8'd0, 8'd4, 16'd0);
        run_sched(4'b1111, 1, 4'b0000, 0, 0, 0, 10, f, no, nb);
        checks++;
        if (no != 0 || nb != 0) begin
            failures++; $display("FAIL mask_zero got=%0d/%0d exp=0/0", no, nb);
        end
    endtask

    task automatic test_reset_mid_pulse;
        int f, no, nb;
        cfg(1'b0, 4'b0001, 8'd0, 8'd4, 16'd10);
        trig_in = 4'b0001;
        tick;
        tick;
        tick;
        checks++;
        if (trig_out !== 1'b1 || trig_count !== 4'd1) begin
            failures++;
            $display("FAIL rst_pre_pulse got=%b/%0d exp=1/1", trig_out, trig_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (trig_out !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_async_out got=%b/%b exp=0/0", trig_out, busy);
        end
        checks++;
        if (trig_count !== 4'd0 || trig_pattern !== 4'b0000) begin
            failures++;
            $display("FAIL rst_async_state got=%0d/%b exp=0/0000", trig_count, trig_pattern);
        end
        #3 reset = 1'b1;
        no = 0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (trig_out === 1'b1) no++;
            if (busy === 1'b1) nb++;
        end
        checks++;
        if (no != 0 || nb != 0) begin
            failures++; $display("FAIL rst_held_high got=%0d/%0d exp=0/0", no, nb);
        end
        trig_in = 4'b0000;
        tick;
        run_sched(4'b0001, 1, 4'b0000, 0, 0, 0, 20, f, no, nb);
        checks++;
        if (f != 3 || no != 4 || trig_count !== 4'd1) begin
            failures++;
            $display("FAIL rst_fresh_edge got=%0d/%0d/%0d exp=3/4/1", f, no, trig_count);
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        ch_mask   = 4'b0000;
        mode      = 1'b0;
        window    = 8'd0;
        width     = 8'd1;
        deadtime  = 16'd0;
        veto      = 1'b0;
        count_clr = 1'b0;
        trig_in   = 4'b0000;
        #12;
        test_reset();
        reset = 1'b1;
        tick;
        tick;
        test_or_mode();
        test_and_mode();
        test_veto();
        test_deadtime();
        test_width_zero();
        test_wrap();
        test_mask_zero();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
